icache_req_arbiter: RTL and testbench

Arbitrates the single instruction-cache fetch port (`ariane_pkg::icache_dreq_i_t` / `icache_dreq_o_t`) between `NumReq` fetch requesters (frontend fetch, prefetcher, debug fetch) in the std cache subsystem. Round-robin grant, one outstanding cache request at a time, response routed back to the owner, and per-requester kill mapped onto the cache's `kill_s1`/`kill_s2`. It sits between the requesters and the icache and owns the icache request struct outright.

---
 rtl/icache_req_arbiter_pkg.sv | 43 ++++
 rtl/icache_req_arbiter_rr_arb_ptr.sv | 31 +++
 rtl/icache_req_arbiter.sv | 118 +++++++++++
 tb/tb_icache_req_arbiter.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/icache_req_arbiter_pkg.sv
// Shared types for the icache request arbiter: icache port structs, frontend exception
// record and the arbiter FSM encoding.
package icache_req_arbiter_pkg;

  localparam int unsigned VLEN        = 39;
  localparam int unsigned XLEN        = 64;
  localparam int unsigned FETCH_WIDTH = 32;

  typedef struct packed {
    logic [XLEN-1:0] cause;
    logic [XLEN-1:0] tval;
    logic            valid;
  } frontend_exception_t;

  // Request towards the icache.
  typedef struct packed {
    logic            req;
    logic            kill_s1;
    logic            kill_s2;
    logic            spec;
    logic [VLEN-1:0] vaddr;
  } icache_dreq_i_t;

  // Response from the icache.
  typedef struct packed {
    logic                   ready;
    logic                   valid;
    logic [FETCH_WIDTH-1:0] data;
    logic [VLEN-1:0]        vaddr;
    frontend_exception_t    ex;
  } icache_dreq_o_t;

  typedef enum logic [1:0] {
    StIdle,
    StReq,
    StWait
  } arb_state_e;

  function automatic int unsigned idx_width(int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/icache_req_arbiter_rr_arb_ptr.sv
// Combinational round-robin pick: first eligible index strictly after last_i, wrapping.
module rr_arb_ptr #(
  parameter int unsigned NumReq = 2,
  parameter int unsigned IdxW   = 1
) (
  input  logic [NumReq-1:0] eligible_i,
  input  logic [IdxW-1:0]   last_i,
  output logic              valid_o,
  output logic [IdxW-1:0]   idx_o
);

  int unsigned     cand;
  logic [IdxW-1:0] cand_idx;

  always_comb begin
    valid_o  = 1'b0;
    idx_o    = '0;
    cand     = 0;
    cand_idx = '0;
    // Walk from last+1 up to last+NumReq so the previous winner is considered last.
    for (int unsigned k = 1; k <= NumReq; k++) begin
      cand     = (32'(last_i) + k) % NumReq;
      cand_idx = cand[IdxW-1:0];
      if (!valid_o && eligible_i[cand_idx]) begin
        valid_o = 1'b1;
        idx_o   = cand_idx;
      end
    end
  end

endmodule

// File: rtl/icache_req_arbiter.sv
// Shares the single icache fetch port between NumReq requesters: round-robin grant,
// one outstanding request, response routed to the owner, owner kill mapped to kill_s1/s2.
module icache_req_arbiter
  import icache_req_arbiter_pkg::*;
#(
  parameter int unsigned NumReq = 2
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic [NumReq-1:0]            req_i,
  input  logic [NumReq-1:0][VLEN-1:0]  vaddr_i,
  input  logic [NumReq-1:0]            kill_i,
  output logic [NumReq-1:0]            gnt_o,
  output logic [NumReq-1:0]            rvalid_o,
  output logic [FETCH_WIDTH-1:0]       rdata_o,
  output logic [VLEN-1:0]              rvaddr_o,
  output frontend_exception_t          rex_o,
  output icache_dreq_i_t               icache_dreq_o,
  input  icache_dreq_o_t               icache_dreq_i
);

  localparam int unsigned     IdxW     = idx_width(NumReq);
  localparam logic [IdxW-1:0] LastInit = IdxW'(NumReq - 1);

  arb_state_e      state_q;
  logic [IdxW-1:0] last_gnt_q;
  logic [IdxW-1:0] owner_q;
  logic [VLEN-1:0] vaddr_q;

  logic [NumReq-1:0] eligible;
  logic              win_valid;
  logic [IdxW-1:0]   win_idx;
  logic              owner_kill;

  assign eligible   = req_i & ~kill_i;
  assign owner_kill = kill_i[owner_q];

  rr_arb_ptr #(
    .NumReq (NumReq),
    .IdxW   (IdxW)
  ) u_rr_arb_ptr (
    .eligible_i (eligible),
    .last_i     (last_gnt_q),
    .valid_o    (win_valid),
    .idx_o      (win_idx)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= StIdle;
      last_gnt_q <= LastInit;
      owner_q    <= '0;
      vaddr_q    <= '0;
    end else begin
      case (state_q)
        StIdle: begin
          if (win_valid) begin
            owner_q    <= win_idx;
            last_gnt_q <= win_idx;
            vaddr_q    <= vaddr_i[win_idx];
            state_q    <= StReq;
          end
        end
        StReq: begin
          if (owner_kill)               state_q <= StIdle;
          else if (icache_dreq_i.ready) state_q <= StWait;
        end
        StWait: begin
          if (owner_kill || icache_dreq_i.valid) state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  // Reset gates every strobe so an abort takes effect in the same cycle.
  always_comb begin
    gnt_o               = '0;
    rvalid_o            = '0;
    icache_dreq_o       = '0;
    icache_dreq_o.vaddr = vaddr_q;
    if (!rst_i) begin
      case (state_q)
        StIdle: begin
          if (win_valid) gnt_o[win_idx] = 1'b1;
        end
        StReq: begin
          icache_dreq_o.req = !owner_kill;
        end
        StWait: begin
          if (owner_kill) begin
            icache_dreq_o.kill_s1 = 1'b1;
            icache_dreq_o.kill_s2 = 1'b1;
          end else if (icache_dreq_i.valid) begin
            rvalid_o[owner_q] = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign rdata_o  = icache_dreq_i.data;
  assign rvaddr_o = icache_dreq_i.vaddr;
  assign rex_o    = icache_dreq_i.ex;

`ifndef SYNTHESIS
  a_gnt_onehot : assert property (@(posedge clk_i) $onehot0(gnt_o));
  a_rvalid_onehot : assert property (@(posedge clk_i) $onehot0(rvalid_o));
  a_valid_in_wait : assert property (@(posedge clk_i) disable iff (rst_i)
    icache_dreq_i.valid |-> (state_q == StWait));
  for (genvar i = 0; i < NumReq; i++) begin : g_vaddr_stable
    a_vaddr_stable : assert property (@(posedge clk_i) disable iff (rst_i)
      (req_i[i] && !gnt_o[i] && !kill_i[i]) ##1 req_i[i] |-> $stable(vaddr_i[i]));
  end
`endif

endmodule

// File: tb/tb_icache_req_arbiter.sv
// Directed bench for icache_req_arbiter: reset, contention, single fetch, kills, reset abort.
module tb_icache_req_arbiter;
  import icache_req_arbiter_pkg::*;

  localparam logic [VLEN-1:0] V0 = VLEN'(64'h8000_0000);
  localparam logic [VLEN-1:0] V1 = VLEN'(64'h8000_1000);

  logic                      clk = 1'b0;
  logic                      rst;
  logic [1:0]                req;
  logic [1:0][VLEN-1:0]      vaddr;
  logic [1:0]                kill;
  logic [1:0]                gnt;
  logic [1:0]                rvalid;
  logic [FETCH_WIDTH-1:0]    rdata;
  logic [VLEN-1:0]           rvaddr;
  frontend_exception_t       rex;
  icache_dreq_i_t            ic_req;
  icache_dreq_o_t            ic_rsp;

  int checks = 0;
  int errors = 0;
  logic [1:0] exp_gnt;

  always #5 clk = ~clk;

  icache_req_arbiter #(
    .NumReq (2)
  ) dut (
    .clk_i         (clk),
    .rst_i         (rst),
    .req_i         (req),
    .vaddr_i       (vaddr),
    .kill_i        (kill),
    .gnt_o         (gnt),
    .rvalid_o      (rvalid),
    .rdata_o       (rdata),
    .rvaddr_o      (rvaddr),
    .rex_o         (rex),
    .icache_dreq_o (ic_req),
    .icache_dreq_i (ic_rsp)
  );

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    rst      = 1'b1;
    req      = 2'b11;
    kill     = 2'b00;
    vaddr[0] = V0;
    vaddr[1] = V1;
    ic_rsp   = '0;

    // Reset: strobes gated even with requests pending.
    cyc();
    cyc();
    #2;
    chk("rst_gnt", 64'(gnt), 64'h0);
    chk("rst_req", 64'(ic_req.req), 64'h0);
    chk("rst_vaddr", 64'(ic_req.vaddr), 64'h0);
    chk("rst_kill", 64'({ic_req.kill_s1, ic_req.kill_s2}), 64'h0);
    chk("rst_rvalid", 64'(rvalid), 64'h0);

    // Contention: both requesting, grants alternate starting with requester 0.
    cyc();
    rst          = 1'b0;
    ic_rsp.ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      exp_gnt = (k % 2 == 0) ? 2'b01 : 2'b10;
      #2;
      chk("rr_gnt", 64'(gnt), 64'(exp_gnt));
      cyc();
      #2;
      chk("rr_req", 64'(ic_req.req), 64'h1);
      chk("rr_vaddr", 64'(ic_req.vaddr), 64'((k % 2 == 0) ? V0 : V1));
      cyc();
      ic_rsp.valid = 1'b1;
      ic_rsp.data  = FETCH_WIDTH'(32'h1000 + k);
      #2;
      chk("rr_rvalid", 64'(rvalid), 64'(exp_gnt));
      cyc();
      ic_rsp.valid = 1'b0;
    end

    // Single requester, ready immediately, response two cycles after req.
    req = 2'b01;
    #2;
    chk("single_gnt", 64'(gnt), 64'h1);
    cyc();
    req = 2'b00;
    #2;
    chk("single_req", 64'(ic_req.req), 64'h1);
    chk("single_spec", 64'(ic_req.spec), 64'h0);
    chk("single_vaddr", 64'(ic_req.vaddr), 64'(V0));
    cyc();
    #2;
    chk("single_wait_req", 64'(ic_req.req), 64'h0);
    chk("single_wait_rvalid", 64'(rvalid), 64'h0);
    cyc();
    ic_rsp.valid = 1'b1;
    ic_rsp.data  = 32'hdead_beef;
    ic_rsp.vaddr = V0;
    #2;
    chk("single_rvalid", 64'(rvalid), 64'h1);
    chk("single_rvaddr", 64'(rvaddr), 64'(V0));
    chk("single_rdata", 64'(rdata), 64'hdead_beef);
    cyc();
    ic_rsp.valid = 1'b0;

    // Kill in REQ with ready low.
    ic_rsp.ready = 1'b0;
    req          = 2'b01;
    #2;
    chk("kreq_gnt", 64'(gnt), 64'h1);
    cyc();
    req = 2'b00;
    #2;
    chk("kreq_req_before", 64'(ic_req.req), 64'h1);
    cyc();
    kill = 2'b01;
    #2;
    chk("kreq_req_drop", 64'(ic_req.req), 64'h0);
    chk("kreq_kill", 64'({ic_req.kill_s1, ic_req.kill_s2}), 64'h0);
    chk("kreq_rvalid", 64'(rvalid), 64'h0);
    cyc();
    kill         = 2'b00;
    req          = 2'b10;
    ic_rsp.ready = 1'b1;
    #2;
    chk("kreq_idle_gnt", 64'(gnt), 64'h2);

    // Kill in WAIT coincident with valid; requester 0 waiting.
    cyc();
    req = 2'b01;
    #2;
    chk("kwait_req", 64'(ic_req.req), 64'h1);
    chk("kwait_vaddr", 64'(ic_req.vaddr), 64'(V1));
    cyc();
    kill         = 2'b10;
    ic_rsp.valid = 1'b1;
    ic_rsp.vaddr = V1;
    #2;
    chk("kwait_kill", 64'({ic_req.kill_s1, ic_req.kill_s2}), 64'h3);
    chk("kwait_rvalid", 64'(rvalid), 64'h0);
    cyc();
    kill         = 2'b00;
    ic_rsp.valid = 1'b0;
    #2;
    chk("kwait_next_gnt", 64'(gnt), 64'h1);

    // Non-owner kill while owner 0 receives its response.
    cyc();
    req = 2'b00;
    #2;
    chk("nokill_req", 64'(ic_req.req), 64'h1);
    cyc();
    kill            = 2'b10;
    ic_rsp.valid    = 1'b1;
    ic_rsp.data     = 32'hcafe_f00d;
    ic_rsp.vaddr    = V0;
    ic_rsp.ex.valid = 1'b1;
    ic_rsp.ex.cause = 64'h1;
    #2;
    chk("nokill_rvalid", 64'(rvalid), 64'h1);
    chk("nokill_kill", 64'({ic_req.kill_s1, ic_req.kill_s2}), 64'h0);
    chk("nokill_rdata", 64'(rdata), 64'hcafe_f00d);
    chk("nokill_rex", 64'(rex.valid), 64'h1);
    cyc();
    kill      = 2'b00;
    ic_rsp    = '0;
    ic_rsp.ready = 1'b1;
    req       = 2'b01;
    #2;
    chk("rstw_gnt", 64'(gnt), 64'h1);

    // Reset while in WAIT, then requester 0 must win despite last grant being 0.
    cyc();
    req = 2'b11;
    #2;
    chk("rstw_req", 64'(ic_req.req), 64'h1);
    cyc();
    rst = 1'b1;
    #2;
    chk("rstw_abort_kill", 64'({ic_req.kill_s1, ic_req.kill_s2}), 64'h0);
    chk("rstw_abort_gnt", 64'(gnt), 64'h0);
    cyc();
    #2;
    chk("rstw_vaddr", 64'(ic_req.vaddr), 64'h0);
    chk("rstw_req_low", 64'(ic_req.req), 64'h0);
    chk("rstw_rvalid", 64'(rvalid), 64'h0);
    cyc();
    rst = 1'b0;
    #2;
    chk("rstw_first_gnt", 64'(gnt), 64'h1);
    cyc();
    req = 2'b00;
    #2;
    chk("rstw_req_vaddr", 64'(ic_req.vaddr), 64'(V0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
